dmem_arbiter: RTL

Shares the single-port data RAM (async read, sync write, 4096×16) between the pipeline's MEM stage and a host/debug burst port used for program-data loading and memory dumps. The MEM stage has priority. The host receives every slot the MEM stage leaves idle. A starvation counter forces one host slot, with a pipeline hold, after MAX_WAIT consecutive denied beats. The block sits between the MEM stage and the data RAM instance.

---
 rtl/dmem_arbiter.sv | 78 +++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data RAM between the MEM stage (priority) and a host burst port with starvation relief
module dmem_arbiter #(
  parameter int AW = 12,
  parameter int DW = 16,
  parameter int LW = 8,
  parameter int MAX_WAIT = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_hold,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [LW-1:0] host_len,
  input  logic [DW-1:0] host_wdata,
  output logic          host_wready,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic          host_busy,
  output logic          host_done,
  output logic [AW-1:0] ram_raddr,
  output logic [AW-1:0] ram_waddr,
  output logic          ram_wen,
  output logic [DW-1:0] ram_win,
  input  logic [DW-1:0] ram_rout
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;
  state_t state;
  logic dir, beat;
  logic [AW-1:0] addr;
  logic [LW-1:0] cnt;
  logic [WW-1:0] wait_cnt;
  assign cpu_rdata = ram_rout;
  assign host_busy = state != IDLE;
  assign host_done = state == DONE;
  // reset suppresses every RAM write so an aborted burst cannot land a beat during the reset cycle
  always_comb begin
    cpu_hold = state == BURST && wait_cnt == WW'(MAX_WAIT);
    beat = !reset && state == BURST && (!cpu_req || cpu_hold);
    ram_raddr = beat ? addr : cpu_addr;
    ram_waddr = ram_raddr;
    ram_win = beat ? host_wdata : cpu_wdata;
    ram_wen = !reset && (beat ? dir : cpu_req && cpu_we && !cpu_hold);
    host_wready = beat && dir;
  end
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      dir <= 1'b0;
      addr <= '0;
      cnt <= '0;
      wait_cnt <= '0;
      host_rdata <= '0;
      host_rvalid <= 1'b0;
    end else begin
      host_rvalid <= beat && !dir;
      if (beat && !dir) host_rdata <= ram_rout;
      if (state == IDLE && host_req) begin
        state <= BURST;
        dir <= host_we;
        addr <= host_addr;
        cnt <= host_len;
        wait_cnt <= '0;
      end else if (beat) begin
        addr <= addr + AW'(1);
        cnt <= cnt - LW'(1);
        wait_cnt <= '0;
        if (cnt == '0) state <= DONE;
      end else if (state == BURST && cpu_req) wait_cnt <= wait_cnt + WW'(1);
      else if (state == DONE) state <= IDLE;
    end
endmodule
